// File: rtl/add_code_decoder.sv
// Recovers data[3:2] from the encoder's 3-bit add code stream and buffers it in a small FIFO.
// Code 5 is passed through flagged as an error; codes 0, 6 and 7 are dropped and counted.
module add_code_decoder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_add,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_msb,
   output logic                     out_err,
   output logic [CNT_W-1:0]         dflt_cnt,
   output logic [CNT_W-1:0]         ill_cnt,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   // Each entry is {msb[1:0], err}
   logic [2:0]       mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] dflt_q, dflt_d;
   logic [CNT_W-1:0] ill_q, ill_d;

   logic       accept, push, pop;
   logic       legal, is_dflt;
   logic [2:0] entry;

   always_comb begin
      entry   = 3'b000;
      legal   = 1'b1;
      is_dflt = 1'b0;
      case (in_add)
         3'd1:    entry = 3'b000;
         3'd2:    entry = 3'b010;
         3'd3:    entry = 3'b100;
         3'd4:    entry = 3'b110;
         3'd5: begin
            entry   = 3'b001;
            is_dflt = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign in_ready  = rst_n & (level_q != FULL);
   assign out_valid = (level_q != '0);
   assign accept    = in_valid & in_ready;
   assign push      = accept & legal;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      dflt_d   = dflt_q;
      ill_d    = ill_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // Saturating status counters
      if (accept && is_dflt && (dflt_q != '1)) dflt_d = dflt_q + CNT_W'(1);
      if (accept && !legal && (ill_q != '1))   ill_d  = ill_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dflt_q   <= '0;
         ill_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dflt_q   <= dflt_d;
         ill_q    <= ill_d;
      end
   end

   // Storage needs no reset: the pointers and level define what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= entry;
   end

   assign out_msb  = out_valid ? mem[rd_ptr_q][2:1] : 2'b00;
   assign out_err  = out_valid ? mem[rd_ptr_q][0] : 1'b0;
   assign dflt_cnt = dflt_q;
   assign ill_cnt  = ill_q;
   assign level    = level_q;

endmodule
